// File: rtl/aer_pkg.sv
// Shared types and constants for the AER input arbitration path.
package aer_pkg;

  localparam int unsigned M_DEFAULT   = 8;
  localparam int unsigned AW          = 2 * M_DEFAULT + 1;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SRC_REL = 2'd1,
    OUT_ACK = 2'd2,
    OUT_REL = 2'd3
  } arb_state_t;

  function automatic int unsigned aw_of(input int unsigned m);
    return 2 * m + 1;
  endfunction

endpackage

// File: rtl/aer_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module aer_rr_pick #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned SW   = 2
) (
  input  logic [NSRC-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            valid,
  output logic [SW-1:0]   idx
);

  logic [2*NSRC-1:0] w_dbl;
  logic [NSRC-1:0]   w_rot;

  // Rotating a doubled copy puts the ptr position at bit 0, so the
  // search becomes a plain lowest-set-bit scan.
  always_comb begin
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[NSRC-1:0];
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!valid && w_rot[k]) begin
        valid = 1'b1;
        idx   = SW'((32'(ptr) + k) % NSRC);
      end
    end
  end

endmodule

// File: rtl/aer_in_arbiter.sv
// Merges NSRC asynchronous 4-phase AER sources onto the core's single AER input port.
module aer_in_arbiter
  import aer_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned M    = 8,
  parameter int unsigned SW   = 2
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      ARB_EN,
  input  logic [NSRC*(2*M+1)-1:0]   SRC_ADDR,
  input  logic [NSRC-1:0]           SRC_REQ,
  output logic [NSRC-1:0]           SRC_ACK,
  output logic [2*M:0]              AERIN_ADDR,
  output logic                      AERIN_REQ,
  input  logic                      AERIN_ACK,
  output logic [SW-1:0]             GRANT_ID,
  output logic                      BUSY
);

  localparam int unsigned AWL = aw_of(M);

  logic [NSRC-1:0] r_sync [SYNC_STAGES];
  logic [NSRC-1:0] w_req_s;
  logic [AWL-1:0]  w_src_addr [NSRC];
  logic            w_valid;
  logic [SW-1:0]   w_idx;

  arb_state_t      r_state;
  logic [NSRC-1:0] r_ack;
  logic            r_req;
  logic [AWL-1:0]  r_addr;
  logic [SW-1:0]   r_gid;
  logic [SW-1:0]   r_ptr;
  logic            r_busy;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= SRC_REQ;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign w_src_addr[g] = SRC_ADDR[g*AWL +: AWL];
  end

  aer_rr_pick #(
    .NSRC (NSRC),
    .SW   (SW)
  ) u_pick (
    .req   (w_req_s),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Source address is bundled data; this is the only cycle it is sampled.
          if (ARB_EN && w_valid) begin
            r_addr  <= w_src_addr[w_idx];
            r_gid   <= w_idx;
            r_ack   <= NSRC'(1) << w_idx;
            r_busy  <= 1'b1;
            r_state <= SRC_REL;
          end
        end
        SRC_REL: begin
          if (!w_req_s[r_gid]) begin
            r_ack   <= '0;
            r_req   <= 1'b1;
            r_state <= OUT_ACK;
          end
        end
        OUT_ACK: begin
          if (AERIN_ACK) begin
            r_req   <= 1'b0;
            r_state <= OUT_REL;
          end
        end
        OUT_REL: begin
          if (!AERIN_ACK) begin
            r_ptr   <= (r_gid == SW'(NSRC - 1)) ? '0 : SW'(r_gid + 1'b1);
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SRC_ACK    = r_ack;
  assign AERIN_REQ  = r_req;
  assign AERIN_ADDR = r_addr;
  assign GRANT_ID   = r_gid;
  assign BUSY       = r_busy;

endmodule

// File: doc/aer_in_arbiter.md
Name: aer_in_arbiter

Overview:
- Merges NSRC independent asynchronous 4-phase AER input channels into the single 17-bit AERIN_ADDR/REQ/ACK port of the core controller.
- Synchronises each source REQ, picks one requester round-robin, and captures its address.
- Completes the source-side handshake, then replays the event on the core-side handshake.
- Sits between the chip pads / inter-core links and the ODIN-style core; runs on the core clock.

Parameters:
- NSRC, 4, number of input AER sources (2..16).
- M, 8, log2 of neuron count; event address width AW = 2*M+1 (17 by default).
- SW, 2, grant index width; must equal ceil(log2(NSRC)).

Ports:
- CLK  in  1  core clock.
- RSTN  in  1  asynchronous active-low reset.
- ARB_EN  in  1  when low, no new grant is issued; an in-flight event completes.
- SRC_ADDR  in  NSRC*AW  source addresses; source i occupies bits [i*AW +: AW]; bundled data, stable while SRC_REQ[i] is high.
- SRC_REQ  in  NSRC  asynchronous source requests.
- SRC_ACK  out  NSRC  source acknowledges, registered.
- AERIN_ADDR  out  AW  event address to the core, registered.
- AERIN_REQ  out  1  request to the core, registered.
- AERIN_ACK  in  1  core acknowledge, synchronous to CLK; not resynchronised.
- GRANT_ID  out  SW  index of the current or last granted source.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RSTN low, async): SRC_ACK=0, AERIN_REQ=0, AERIN_ADDR=0, GRANT_ID=0, BUSY=0, state=IDLE, rr_ptr=0, sync flops=0.
- Reset mid-operation aborts the event silently. A source that still holds REQ high is re-arbitrated after reset release.
- Each SRC_REQ bit goes through a 2-flop synchroniser, giving req_s. A rising SRC_REQ is visible in req_s 2 cycles later.
- State IDLE:
  - If ARB_EN=1 and req_s is non-zero, pick the first set bit at or after rr_ptr, wrapping from NSRC-1 to 0.
  - Latch SRC_ADDR of the winner into AERIN_ADDR and the winner index into GRANT_ID.
  - Assert SRC_ACK[winner] and go to SRC_REL.
  - Addresses are sampled only in this cycle.
- State SRC_REL: when req_s[GRANT_ID]=0, deassert SRC_ACK, assert AERIN_REQ, go to OUT_ACK.
- State OUT_ACK: when AERIN_ACK=1, deassert AERIN_REQ, go to OUT_REL.
- State OUT_REL: when AERIN_ACK=0, set rr_ptr = (GRANT_ID+1) mod NSRC and go to IDLE.
- Grant latency and outputs:
  - Minimum latency from SRC_REQ rise to SRC_ACK rise is 3 cycles: 2 for sync, 1 for the registered grant.
  - Minimum latency from source release (SRC_REQ fall) to AERIN_REQ rise is 3 cycles.
  - Exactly one SRC_ACK bit is high at any time, and only in SRC_REL. SRC_ACK and AERIN_REQ are never high together.
  - AERIN_ADDR is stable from 1 cycle before AERIN_REQ rises until the return to IDLE.
- Simultaneous requests: resolved by rr_ptr order. A continuously requesting source waits at most NSRC-1 events.
- Ignored inputs:
  - A source that drops REQ before it is granted is simply not selected.
  - A REQ glitch shorter than 2 cycles may be missed; this is allowed.
  - AERIN_ACK while in IDLE or SRC_REL is ignored.
- ARB_EN is sampled only in IDLE. Deasserting it mid-event has no effect on that event.
- No timeouts: a stuck source or a stuck core holds the FSM in its current state indefinitely. BUSY stays high.

Decomposition:
- Shared package aer_pkg:
  - AW localparam (2*M+1).
  - State enum IDLE=2'd0, SRC_REL=2'd1, OUT_ACK=2'd2, OUT_REL=2'd3.
  - Sync depth constant SYNC_STAGES=2.
- Sub-module aer_rr_pick: combinational round-robin picker. Inputs req[NSRC], ptr[SW]. Outputs valid and idx[SW]. Reusable for future output arbitration.
- Synchronisers stay inline in aer_in_arbiter.

Test Plan:
- Single event: SRC_REQ[2]=1 with SRC_ADDR[2]=17'h1_0A5. Then:
  - SRC_ACK[2] rises 3 cycles later.
  - Bench drops SRC_REQ[2]; AERIN_REQ rises with AERIN_ADDR=17'h1_0A5.
  - Bench ACK handshake completes; rr_ptr=3, BUSY=0.
- Contention: SRC_REQ=4'b1111 held with distinct addresses. Grants occur in order 0,1,2,3,0 and each AERIN_ADDR matches its source.
- Fairness after wrap: rr_ptr=3 and SRC_REQ=4'b1001 at the same cycle. Source 3 is granted, then source 0.
- ARB_EN: ARB_EN=0 with SRC_REQ[1]=1 for 50 cycles gives no SRC_ACK. Raising ARB_EN grants source 1 within 1 cycle.
- Slow core: AERIN_ACK withheld 100 cycles. AERIN_REQ stays high and AERIN_ADDR stays stable; new SRC_REQ[0] gets no ACK until OUT_REL completes.
- Reset mid-event: RSTN=0 while in OUT_ACK. All outputs go to 0 immediately; after release with SRC_REQ[2] still high, source 2 is re-granted.
